// File: rtl/mips_pkg.sv
// Shared pipeline constants: forwarding mux selects, MD sequencer states and latencies.
package mips_pkg;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b01;

  localparam int unsigned MUL_LAT_DEFAULT = 5;
  localparam int unsigned DIV_LAT_DEFAULT = 32;
  localparam int unsigned CNT_W_DEFAULT   = 6;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } md_state_t;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Datapath <-> hazard controller signal bundle; the datapath is the master.
interface hazard_if;

  logic [4:0] RsD, RtD, RsE, RtE;
  logic [4:0] WriteRegE, WriteRegM, WriteRegW;
  logic       RegWriteE, RegWriteM, RegWriteW;
  logic       MemtoRegE, MemtoRegM;
  logic       BranchD, JumpRegD, TakenD;
  logic       MdUseD, MdStartE, MdIsDivE;

  logic       EnF, EnD, FlushD, FlushE;
  logic       ForwardAD, ForwardBD;
  logic [1:0] ForwardAE, ForwardBE;
  logic       MdBusy, MdDone;

  modport master (
    output RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW,
           RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM,
           BranchD, JumpRegD, TakenD, MdUseD, MdStartE, MdIsDivE,
    input  EnF, EnD, FlushD, FlushE, ForwardAD, ForwardBD,
           ForwardAE, ForwardBE, MdBusy, MdDone
  );

  modport slave (
    input  RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW,
           RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM,
           BranchD, JumpRegD, TakenD, MdUseD, MdStartE, MdIsDivE,
    output EnF, EnD, FlushD, FlushE, ForwardAD, ForwardBD,
           ForwardAE, ForwardBE, MdBusy, MdDone
  );

endinterface

// File: rtl/hazard_ctrl_md_seq.sv
// Multiply/divide occupancy sequencer: IDLE/BUSY FSM with a down-counter.
module md_seq
  import mips_pkg::*;
#(
  parameter int unsigned MUL_LAT = MUL_LAT_DEFAULT,
  parameter int unsigned DIV_LAT = DIV_LAT_DEFAULT,
  parameter int unsigned CNT_W   = CNT_W_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic is_div,
  output logic busy,
  output logic done
);

  localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'(DIV_LAT - 1);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  md_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // A start seen while BUSY is ignored: no restart of the running operation.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = BUSY;
          cnt_d   = is_div ? DIV_CNT : MUL_CNT;
        end
      end
      BUSY: begin
        if (cnt_q == ONE) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - ONE;
        end
      end
    endcase
  end

  assign busy = (state_q == BUSY);
  assign done = busy && (cnt_q == ONE);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: forwarding selects, load/branch/mult-div stalls, F/D/E enables and flushes.
module hazard_ctrl
  import mips_pkg::*;
#(
  parameter int unsigned MUL_LAT = MUL_LAT_DEFAULT,
  parameter int unsigned DIV_LAT = DIV_LAT_DEFAULT,
  parameter int unsigned CNT_W   = CNT_W_DEFAULT
) (
  input  logic     clk,
  input  logic     reset,
  hazard_if.slave  hz
);

  logic lwstall, brstall, mdstall, stall;
  logic e_hit, m_hit;
  logic md_busy, md_done;

  md_seq #(
    .MUL_LAT (MUL_LAT),
    .DIV_LAT (DIV_LAT),
    .CNT_W   (CNT_W)
  ) u_md_seq (
    .clk    (clk),
    .reset  (reset),
    .start  (hz.MdStartE),
    .is_div (hz.MdIsDivE),
    .busy   (md_busy),
    .done   (md_done)
  );

  always_comb begin
    hz.ForwardAE = FWD_RF;
    if (hz.RsE != '0 && hz.RegWriteM && hz.WriteRegM == hz.RsE)
      hz.ForwardAE = FWD_MEM;
    else if (hz.RsE != '0 && hz.RegWriteW && hz.WriteRegW == hz.RsE)
      hz.ForwardAE = FWD_WB;

    hz.ForwardBE = FWD_RF;
    if (hz.RtE != '0 && hz.RegWriteM && hz.WriteRegM == hz.RtE)
      hz.ForwardBE = FWD_MEM;
    else if (hz.RtE != '0 && hz.RegWriteW && hz.WriteRegW == hz.RtE)
      hz.ForwardBE = FWD_WB;
  end

  assign hz.ForwardAD = (hz.RsD != '0) && hz.RegWriteM && (hz.WriteRegM == hz.RsD);
  assign hz.ForwardBD = (hz.RtD != '0) && hz.RegWriteM && (hz.WriteRegM == hz.RtD);

  // Rt only matters for branches; jr/jalr read Rs alone.
  assign e_hit = hz.RegWriteE && (hz.WriteRegE != '0) &&
                 ((hz.WriteRegE == hz.RsD) || (hz.BranchD && hz.WriteRegE == hz.RtD));
  assign m_hit = hz.MemtoRegM && (hz.WriteRegM != '0) &&
                 ((hz.WriteRegM == hz.RsD) || (hz.BranchD && hz.WriteRegM == hz.RtD));

  assign lwstall = hz.MemtoRegE && ((hz.RtE == hz.RsD) || (hz.RtE == hz.RtD));
  assign brstall = (hz.BranchD || hz.JumpRegD) && (e_hit || m_hit);
  assign mdstall = hz.MdUseD && (hz.MdStartE || (md_busy && !md_done));
  assign stall   = lwstall || brstall || mdstall;

  assign hz.EnF    = !stall;
  assign hz.FlushD = hz.TakenD && !stall;
  assign hz.EnD    = !(stall || hz.FlushD);
  assign hz.FlushE = stall;
  assign hz.MdBusy = md_busy;
  assign hz.MdDone = md_done;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus random traffic against a timeline model.
module tb_hazard_ctrl;

  localparam int MUL_LAT = 5;
  localparam int DIV_LAT = 32;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  hazard_if hz ();

  hazard_ctrl #(
    .MUL_LAT (MUL_LAT),
    .DIV_LAT (DIV_LAT),
    .CNT_W   (6)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .hz    (hz.slave)
  );

  int n_vec  = 0;
  int n_err  = 0;
  int cyc    = 0;
  int md_end = -1;   // last cycle index during which the MD unit reports busy

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [1:0] ref_fwd_e(input int src);
    if (src != 0 && hz.RegWriteM && int'(hz.WriteRegM) == src) return 2'b10;
    if (src != 0 && hz.RegWriteW && int'(hz.WriteRegW) == src) return 2'b01;
    return 2'b00;
  endfunction

  function automatic bit ref_busy();
    return cyc <= md_end;
  endfunction

  // Whether the D instruction depends on a register being produced by stage E or a load in M.
  function automatic bit ref_brstall();
    int srcs[$];
    bit hit = 0;
    if (!(hz.BranchD || hz.JumpRegD)) return 0;
    srcs.push_back(int'(hz.RsD));
    if (hz.BranchD) srcs.push_back(int'(hz.RtD));
    foreach (srcs[i]) begin
      if (hz.RegWriteE && hz.WriteRegE != 0 && int'(hz.WriteRegE) == srcs[i]) hit = 1;
      if (hz.MemtoRegM && hz.WriteRegM != 0 && int'(hz.WriteRegM) == srcs[i]) hit = 1;
    end
    return hit;
  endfunction

  task automatic check_all();
    bit busy, done, lw, md, st, fl;
    busy = ref_busy();
    done = (cyc == md_end);
    lw   = hz.MemtoRegE && (hz.RtE == hz.RsD || hz.RtE == hz.RtD);
    md   = hz.MdUseD && (hz.MdStartE || (busy && !done));
    st   = lw || ref_brstall() || md;
    fl   = hz.TakenD && !st;
    check_eq("ForwardAE", hz.ForwardAE, ref_fwd_e(int'(hz.RsE)));
    check_eq("ForwardBE", hz.ForwardBE, ref_fwd_e(int'(hz.RtE)));
    check_eq("ForwardAD", hz.ForwardAD, hz.RsD != 0 && hz.RegWriteM && hz.WriteRegM == hz.RsD);
    check_eq("ForwardBD", hz.ForwardBD, hz.RtD != 0 && hz.RegWriteM && hz.WriteRegM == hz.RtD);
    check_eq("EnF", hz.EnF, !st);
    check_eq("EnD", hz.EnD, !st && !fl);
    check_eq("FlushD", hz.FlushD, fl);
    check_eq("FlushE", hz.FlushE, st);
    check_eq("MdBusy", hz.MdBusy, busy);
    check_eq("MdDone", hz.MdDone, done);
  endtask

  task automatic step();
    @(negedge clk);
    check_all();
    @(posedge clk);
    assert (reset || !(hz.MdStartE && hz.MdBusy && !hz.MdDone))
      else $error("MdStartE asserted while MD unit busy");
    if (reset) md_end = -1;
    else if (hz.MdStartE && !ref_busy())
      md_end = cyc + (hz.MdIsDivE ? DIV_LAT : MUL_LAT) - 1;
    cyc++;
    #1;
  endtask

  task automatic clear_inputs();
    reset = 0;
    hz.RsD = 0; hz.RtD = 0; hz.RsE = 0; hz.RtE = 0;
    hz.WriteRegE = 0; hz.WriteRegM = 0; hz.WriteRegW = 0;
    hz.RegWriteE = 0; hz.RegWriteM = 0; hz.RegWriteW = 0;
    hz.MemtoRegE = 0; hz.MemtoRegM = 0;
    hz.BranchD = 0; hz.JumpRegD = 0; hz.TakenD = 0;
    hz.MdUseD = 0; hz.MdStartE = 0; hz.MdIsDivE = 0;
  endtask

  initial begin
    int busy_cnt, stall_cnt;
    clear_inputs();
    reset = 1;
    step(); step();
    reset = 0;
    #1 check_eq("rst_MdBusy", hz.MdBusy, 0);
    check_eq("rst_MdDone", hz.MdDone, 0);

    // load-use, then the loaded value arrives through W
    hz.MemtoRegE = 1; hz.RtE = 8; hz.RsD = 8;
    #1 check_eq("lu_EnF", hz.EnF, 0);
    check_eq("lu_FlushE", hz.FlushE, 1);
    step();
    clear_inputs();
    hz.RsE = 8; hz.RegWriteW = 1; hz.WriteRegW = 8;
    #1 check_eq("lu_fwdW", hz.ForwardAE, 2'b01);
    step();

    // M beats W; register 0 never forwards
    clear_inputs();
    hz.RsE = 5; hz.WriteRegM = 5; hz.WriteRegW = 5; hz.RegWriteM = 1; hz.RegWriteW = 1;
    #1 check_eq("prio_M", hz.ForwardAE, 2'b10);
    step();
    hz.RsE = 0; hz.WriteRegM = 0; hz.WriteRegW = 0;
    #1 check_eq("prio_zero", hz.ForwardAE, 2'b00);
    step();

    // branch operand in E: stall beats taken; next cycle forward from M and flush
    clear_inputs();
    hz.BranchD = 1; hz.RsD = 9; hz.RegWriteE = 1; hz.WriteRegE = 9; hz.TakenD = 1;
    #1 check_eq("br_stallFlushD", hz.FlushD, 0);
    check_eq("br_stallEnF", hz.EnF, 0);
    step();
    hz.RegWriteE = 0; hz.WriteRegE = 0; hz.RegWriteM = 1; hz.WriteRegM = 9;
    #1 check_eq("br_fwdAD", hz.ForwardAD, 1);
    check_eq("br_FlushD", hz.FlushD, 1);
    check_eq("br_EnD", hz.EnD, 0);
    check_eq("br_EnF", hz.EnF, 1);
    step();

    // divide with a dependent MD instruction waiting in D
    clear_inputs();
    hz.MdStartE = 1; hz.MdIsDivE = 1; hz.MdUseD = 1;
    step();
    hz.MdStartE = 0; hz.MdIsDivE = 0;
    busy_cnt = 0; stall_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (hz.MdBusy) busy_cnt++;
      if (hz.MdBusy && !hz.EnF) stall_cnt++;
      step();
    end
    check_eq("div_busy_cycles", busy_cnt, 31);
    check_eq("div_stall_cycles", stall_cnt, 30);

    // multiply, then a back-to-back mult in D stalls on the start cycle
    hz.MdUseD = 0; hz.MdStartE = 1;
    #1 check_eq("mul_b2b_idle", hz.EnF, 1);
    hz.MdUseD = 1;
    #1 check_eq("mul_b2b_stall", hz.EnF, 0);
    step();
    hz.MdStartE = 0; hz.MdUseD = 0;
    busy_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      #1 if (hz.MdBusy) busy_cnt++;
      step();
    end
    check_eq("mul_busy_cycles", busy_cnt, 4);

    // reset in the middle of a divide
    hz.MdStartE = 1; hz.MdIsDivE = 1;
    step();
    hz.MdStartE = 0; hz.MdIsDivE = 0; hz.MdUseD = 1;
    for (int i = 0; i < 9; i++) step();
    reset = 1;
    step();
    reset = 0;
    #1 check_eq("rstmid_MdBusy", hz.MdBusy, 0);
    check_eq("rstmid_EnF", hz.EnF, 1);
    step();

    // random traffic over a small register window to provoke matches
    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom_range(0, 99) == 0);
      hz.RsD = 5'($urandom_range(0, 3)); hz.RtD = 5'($urandom_range(0, 3));
      hz.RsE = 5'($urandom_range(0, 3)); hz.RtE = 5'($urandom_range(0, 3));
      hz.WriteRegE = 5'($urandom_range(0, 3));
      hz.WriteRegM = 5'($urandom_range(0, 3));
      hz.WriteRegW = 5'($urandom_range(0, 3));
      hz.RegWriteE = 1'($urandom_range(0, 1)); hz.RegWriteM = 1'($urandom_range(0, 1));
      hz.RegWriteW = 1'($urandom_range(0, 1));
      hz.MemtoRegE = ($urandom_range(0, 3) == 0); hz.MemtoRegM = ($urandom_range(0, 3) == 0);
      hz.BranchD = ($urandom_range(0, 2) == 0); hz.JumpRegD = ($urandom_range(0, 4) == 0);
      hz.TakenD = 1'($urandom_range(0, 1)); hz.MdUseD = 1'($urandom_range(0, 1));
      hz.MdStartE = !ref_busy() && ($urandom_range(0, 5) == 0);
      hz.MdIsDivE = ($urandom_range(0, 3) == 0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Central hazard and sequencing controller for the 5-stage MIPS pipeline.
- Drives enable/flush of the F and D pipeline registers and the flush of the E register, and selects the D- and E-stage forwarding muxes.
- Sequences the multicycle multiply/divide unit with a busy counter, stalling dependent HI/LO and mult/div instructions.
- Sits beside the datapath and consumes register-number, control and mult/div-start signals from stages D through W.

Parameters:
- MUL_LAT, 5, total cycles a mult/multu occupies the MD unit (>=2)
- DIV_LAT, 32, total cycles a div/divu occupies the MD unit (>=2, <=63)
- CNT_W, 6, counter width; must hold max(MUL_LAT,DIV_LAT)-1

Ports:
- clk  in  1  clock, all state on posedge
- reset  in  1  synchronous, active-high
- RsD, RtD  in  5  D-stage source register numbers
- RsE, RtE  in  5  E-stage source register numbers
- WriteRegE, WriteRegM, WriteRegW  in  5  destination register per stage
- RegWriteE, RegWriteM, RegWriteW  in  1  destination write enable per stage
- MemtoRegE, MemtoRegM  in  1  instruction in stage is a load
- BranchD  in  1  beq/bne in D (compared in D)
- JumpRegD  in  1  jr/jalr in D (reads Rs in D)
- TakenD  in  1  D-stage redirect (branch taken or any jump)
- MdUseD  in  1  D instruction is mult/div/mfhi/mflo/mthi/mtlo
- MdStartE  in  1  mult/div in E this cycle (start MD unit)
- MdIsDivE  in  1  qualifies MdStartE: 1 = divide
- EnF  out  1  PC register enable
- EnD  out  1  D register enable (load when 1)
- FlushD  out  1  clear D register (effective only when EnD=0)
- FlushE  out  1  clear E register (bubble)
- ForwardAD, ForwardBD  out  1  D comparator operand from ALUOutM
- ForwardAE, ForwardBE  out  2  00 regfile, 10 ALUOutM, 01 ResultW
- MdBusy  out  1  MD unit occupied
- MdDone  out  1  one-cycle pulse on the final busy cycle

Behaviour:
- Forwarding is combinational. ForwardAE=10 if RsE!=0 & RegWriteM & WriteRegM==RsE; else 01 if RsE!=0 & RegWriteW & WriteRegW==RsE; else 00. M has priority over W. ForwardBE is the same on RtE.
- ForwardAD = RsD!=0 & RegWriteM & WriteRegM==RsD. ForwardBD is the same on RtD.
- lwstall = MemtoRegE & (RtE==RsD | RtE==RtD).
- brstall = (BranchD|JumpRegD) & ((RegWriteE & WriteRegE!=0 & (WriteRegE==RsD | (BranchD & WriteRegE==RtD))) | (MemtoRegM & WriteRegM!=0 & (WriteRegM==RsD | (BranchD & WriteRegM==RtD)))).
- mdstall = MdUseD & (MdStartE | (MdBusy & ~MdDone)).
- Stall = lwstall | brstall | mdstall.
- EnF = ~Stall.
- FlushD = TakenD & ~Stall.
- EnD = ~(Stall | FlushD). EnD must be 0 whenever FlushD=1, because the D register gives En priority over flush.
- FlushE = Stall.
- MD FSM has two states, IDLE and BUSY, with counter cnt[CNT_W].
  - IDLE & MdStartE: cnt <= (MdIsDivE ? DIV_LAT : MUL_LAT) - 1, go to BUSY.
  - BUSY: cnt decrements by 1 each cycle.
  - MdDone = BUSY & cnt==1 (combinational).
  - BUSY & cnt==1: go to IDLE, cnt <= 0.
- MdBusy = (state==BUSY). A mult/div therefore holds MdBusy for LAT-1 cycles after its E cycle, and the MD unit is occupied for LAT cycles in total.
- MdStartE while BUSY cannot occur given mdstall. If it does, it is ignored (no restart); assertion-checked in the bench.
- Reset, including mid-BUSY: state=IDLE, cnt=0, MdBusy=0, MdDone=0 in the next cycle. Combinational outputs follow their inputs.
- Simultaneous events:
  - Stall with TakenD: stall wins, no flush, branch re-evaluated next cycle.
  - MdDone cycle with MdUseD: no stall, so the instruction advances as the result becomes ready.

Decomposition:
- Shared package (mips_pkg) holds:
  - forwarding select constants FWD_RF=2'b00, FWD_MEM=2'b10, FWD_WB=2'b01
  - MD state encoding IDLE=1'b0, BUSY=1'b1
  - MUL_LAT and DIV_LAT defaults
- One sub-module is natural: md_seq, the IDLE/BUSY FSM plus counter, producing MdBusy and MdDone.
- Forwarding and stall logic stay in hazard_ctrl.

Test Plan:
- Load-use: MemtoRegE=1, RtE=8, RsD=8 -> Stall=1, EnF=0, EnD=0, FlushE=1 for 1 cycle; next cycle ForwardAE=01 once the load reaches W with WriteRegW=8.
- Forward priority: RsE=5, WriteRegM=5, WriteRegW=5, both RegWrite=1 -> ForwardAE=10. Same with RsE=0 -> 00.
- Branch: BranchD=1, RsD=9, RegWriteE=1, WriteRegE=9 -> Stall=1 and FlushD=0 even with TakenD=1. Next cycle (producer in M, not a load) ForwardAD=1, and TakenD=1 gives FlushD=1, EnD=0, EnF=1.
- Divide: MdStartE=1, MdIsDivE=1 -> MdBusy=1 for 31 cycles; MdDone high on the 31st. MdUseD=1 throughout stalls every cycle except the MdDone cycle.
- Multiply: MdStartE=1, MdIsDivE=0 -> MdBusy 4 cycles, MdDone on the 4th. Back-to-back mult in D sees mdstall on its first cycle (MdStartE=1).
- Reset mid-divide at cycle 10 -> next cycle MdBusy=0, MdDone=0; MdUseD no longer stalls.
